// File: rtl/add_num_job_sched.sv
// rtl/add_num_job_sched.sv - job controller for the add-two-numbers AFU
//
// Reads source lines, sums bytes 1 and 2 of each, writes the 8-bit sum to the
// matching destination line. In-flight lines are bounded by a credit counter,
// and sums wait in a result FIFO until the write channel can take them.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cfg_start/src/dst/num_lines   job configuration from CSR decode
//   rd_req_valid/addr/tag         read request (tag = line index)
//   rd_req_almfull                read channel almost full (gates new issue)
//   rd_rsp_valid/tag/data         read response, any order
//   wr_req_valid/addr/data        write request
//   wr_req_almfull                write channel almost full (gates dequeue)
//   wr_rsp_valid                  write completion
//   busy, done, lines_done        job status

module add_num_job_sched #(
    parameter int ADDR_W          = 42,
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int DATA_W          = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [CNT_W-1:0]  cfg_num_lines,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [CNT_W-1:0]  rd_req_tag,
    input  logic              rd_req_almfull,
    input  logic              rd_rsp_valid,
    input  logic [CNT_W-1:0]  rd_rsp_tag,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_req_almfull,
    input  logic              wr_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  lines_done
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int ENT_W = CNT_W + 8;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]  num_q, issued_q;
    logic [PTR_W:0]    credits_q;

    logic [ENT_W-1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [PTR_W:0]    fifo_cnt_q;

    logic       start_ok, active, issue, enq, deq;
    logic [7:0] rsp_sum;
    logic       unused_data;

    assign start_ok = cfg_start && (state_q == S_IDLE || state_q == S_DONE);
    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign issue    = (state_q == S_RUN) && (issued_q < num_q) &&
                      (credits_q != '0) && !rd_req_almfull;
    // Responses outside a job (e.g. after an abort) are dropped.
    assign enq      = active && rd_rsp_valid;
    assign deq      = (fifo_cnt_q != '0) && !wr_req_almfull;
    assign rsp_sum  = rd_rsp_data[15:8] + rd_rsp_data[23:16];
    assign unused_data = ^{rd_rsp_data[DATA_W-1:24], rd_rsp_data[7:0]};

    assign busy = active;
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start)
                    state_d = (cfg_num_lines == '0) ? S_DONE : S_RUN;
            end
            S_RUN:   if (issued_q == num_q)   state_d = S_DRAIN;
            S_DRAIN: if (lines_done == num_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Entry storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wptr_q] <= {rd_rsp_tag, rsp_sum};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q        <= '0;
            dst_q        <= '0;
            num_q        <= '0;
            issued_q     <= '0;
            credits_q    <= '0;
            lines_done   <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fifo_cnt_q   <= '0;
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_tag   <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_data  <= '0;
        end else begin
            assert (!(enq && fifo_cnt_q == FULL_CNT && !deq));

            rd_req_valid <= issue;
            wr_req_valid <= deq;

            if (start_ok) begin
                src_q      <= cfg_src_addr;
                dst_q      <= cfg_dst_addr;
                num_q      <= cfg_num_lines;
                issued_q   <= '0;
                credits_q  <= FULL_CNT;
                lines_done <= '0;
            end else begin
                if (issue) issued_q <= issued_q + CNT_W'(1);
                // A dequeue frees a credit; issue+dequeue nets to zero.
                if (issue && !deq)      credits_q <= credits_q - (PTR_W+1)'(1);
                else if (!issue && deq) credits_q <= credits_q + (PTR_W+1)'(1);
                if (active && wr_rsp_valid) lines_done <= lines_done + CNT_W'(1);
            end

            if (issue) begin
                rd_req_addr <= src_q + ADDR_W'(issued_q);
                rd_req_tag  <= issued_q;
            end

            if (enq) wptr_q <= wptr_q + PTR_W'(1);
            if (deq) begin
                rptr_q      <= rptr_q + PTR_W'(1);
                wr_req_addr <= dst_q + ADDR_W'(fifo_mem[rptr_q][ENT_W-1:8]);
                wr_req_data <= {{(DATA_W-8){1'b0}}, fifo_mem[rptr_q][7:0]};
            end

            case ({enq, deq})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (PTR_W+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_add_num_job_sched.sv
// tb/tb_add_num_job_sched.sv - directed self-checking bench for add_num_job_sched

module tb_add_num_job_sched;

    localparam int ADDR_W = 42;
    localparam int CNT_W  = 16;
    localparam int MAXO   = 8;
    localparam int DATA_W = 512;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_start = 1'b0;
    logic [ADDR_W-1:0] cfg_src_addr = '0;
    logic [ADDR_W-1:0] cfg_dst_addr = '0;
    logic [CNT_W-1:0]  cfg_num_lines = '0;
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic [CNT_W-1:0]  rd_req_tag;
    logic              rd_req_almfull = 1'b0;
    logic              rd_rsp_valid = 1'b0;
    logic [CNT_W-1:0]  rd_rsp_tag = '0;
    logic [DATA_W-1:0] rd_rsp_data = '0;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;
    logic              wr_req_almfull = 1'b0;
    logic              wr_rsp_valid = 1'b0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_done;

    int total = 0;
    int bad   = 0;

    logic [63:0] rd_addr_q[$];
    logic [63:0] rd_tag_q[$];
    logic [63:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];

    add_num_job_sched #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_OUTSTANDING(MAXO), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_src_addr(cfg_src_addr),
        .cfg_dst_addr(cfg_dst_addr), .cfg_num_lines(cfg_num_lines),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
        .rd_req_tag(rd_req_tag), .rd_req_almfull(rd_req_almfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tag(rd_rsp_tag),
        .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_req_almfull(wr_req_almfull),
        .wr_rsp_valid(wr_rsp_valid),
        .busy(busy), .done(done), .lines_done(lines_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_req_valid) begin
            rd_addr_q.push_back(64'(rd_req_addr));
            rd_tag_q.push_back(64'(rd_req_tag));
        end
        if (wr_req_valid) begin
            wr_addr_q.push_back(64'(wr_req_addr));
            wr_data_q.push_back(wr_req_data[63:0]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        rd_addr_q.delete(); rd_tag_q.delete();
        wr_addr_q.delete(); wr_data_q.delete();
    endtask

    task automatic start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                         input logic [CNT_W-1:0] n);
        @(negedge clk);
        cfg_src_addr = s; cfg_dst_addr = d; cfg_num_lines = n; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic send_rsp(input int tag, input logic [7:0] b1, input logic [7:0] b2);
        @(negedge clk);
        rd_rsp_valid = 1'b1;
        rd_rsp_tag   = CNT_W'(tag);
        rd_rsp_data  = {{(DATA_W-24){1'b1}}, b2, b1, 8'h5A};
        @(negedge clk);
        rd_rsp_valid = 1'b0;
    endtask

    task automatic wr_rsp(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_rsp_valid = 1'b1;
        end
        @(negedge clk);
        wr_rsp_valid = 1'b0;
    endtask

    task automatic wait_rd(input int n, input string tag);
        for (int i = 0; i < 300 && rd_addr_q.size() < n; i++) @(negedge clk);
        chk(tag, 64'(rd_addr_q.size() >= n), 64'd1);
    endtask

    task automatic wait_wr(input int n, input string tag);
        for (int i = 0; i < 300 && wr_addr_q.size() < n; i++) @(negedge clk);
        chk(tag, 64'(wr_addr_q.size() >= n), 64'd1);
    endtask

    function automatic logic [7:0] b1f(input int i);
        return 8'(i * 7);
    endfunction

    function automatic logic [7:0] b2f(input int i);
        return 8'(8'hA0 + i);
    endfunction

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_valid", 64'(rd_req_valid), 0);
        chk("rst_wr_valid", 64'(wr_req_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_lines", 64'(lines_done), 0);
        reset = 1'b0;

        // single line
        start(42'h100, 42'h200, 16'd1);
        wait_rd(1, "single_wait_rd");
        chk("single_rd_addr", rd_addr_q[0], 64'h100);
        chk("single_rd_tag", rd_tag_q[0], 0);
        chk("single_busy", 64'(busy), 1);
        send_rsp(0, 8'h05, 8'h07);
        @(negedge clk);
        chk("single_wr_latency", 64'(wr_req_valid), 1);
        wait_wr(1, "single_wait_wr");
        chk("single_wr_addr", wr_addr_q[0], 64'h200);
        chk("single_wr_data", wr_data_q[0], 64'h0C);
        wr_rsp(1);
        repeat (3) @(negedge clk);
        chk("single_done", 64'(done), 1);
        chk("single_lines", 64'(lines_done), 1);
        chk("single_busy_off", 64'(busy), 0);
        clear_q();

        // 8-bit wrap of the sum
        start(42'h10, 42'h20, 16'd1);
        wait_rd(1, "ovf_wait_rd");
        send_rsp(0, 8'hF0, 8'h20);
        wait_wr(1, "ovf_wait_wr");
        chk("ovf_wr_addr", wr_addr_q[0], 64'h20);
        chk("ovf_wr_data", wr_data_q[0], 64'h10);
        wr_rsp(1);
        repeat (3) @(negedge clk);
        chk("ovf_done", 64'(done), 1);
        clear_q();

        // credit limit
        start(42'h1000, 42'h2000, 16'd20);
        repeat (40) @(negedge clk);
        chk("cred_rd_count8", 64'(rd_addr_q.size()), 8);
        chk("cred_rd_addr7", rd_addr_q[7], 64'h1007);
        send_rsp(0, b1f(0), b2f(0));
        repeat (15) @(negedge clk);
        chk("cred_wr_count1", 64'(wr_addr_q.size()), 1);
        chk("cred_rd_count9", 64'(rd_addr_q.size()), 9);
        for (int t = 1; t < 20; t++) begin
            wait_rd(t + 1, "cred_wait_rd");
            send_rsp(t, b1f(t), b2f(t));
        end
        wait_wr(20, "cred_wait_wr");
        for (int t = 0; t < 20 && t < wr_addr_q.size(); t++) begin
            chk("cred_wr_addr", wr_addr_q[t], 64'h2000 + 64'(t));
            chk("cred_wr_data", wr_data_q[t], 64'(8'(b1f(t) + b2f(t))));
        end
        chk("cred_rd_total", 64'(rd_addr_q.size()), 20);
        wr_rsp(20);
        repeat (3) @(negedge clk);
        chk("cred_lines", 64'(lines_done), 20);
        chk("cred_done", 64'(done), 1);
        clear_q();

        // out-of-order responses
        start(42'h300, 42'h400, 16'd4);
        wait_rd(4, "ooo_wait_rd");
        send_rsp(3, 8'h11, 8'h22);
        send_rsp(0, 8'h01, 8'h02);
        send_rsp(2, 8'h80, 8'h90);
        send_rsp(1, 8'hFF, 8'h01);
        wait_wr(4, "ooo_wait_wr");
        chk("ooo_addr0", wr_addr_q[0], 64'h403);
        chk("ooo_data0", wr_data_q[0], 64'h33);
        chk("ooo_addr1", wr_addr_q[1], 64'h400);
        chk("ooo_data1", wr_data_q[1], 64'h03);
        chk("ooo_addr2", wr_addr_q[2], 64'h402);
        chk("ooo_data2", wr_data_q[2], 64'h10);
        chk("ooo_addr3", wr_addr_q[3], 64'h401);
        chk("ooo_data3", wr_data_q[3], 64'h00);
        wr_rsp(4);
        repeat (3) @(negedge clk);
        chk("ooo_lines", 64'(lines_done), 4);
        clear_q();

        // write backpressure
        wr_req_almfull = 1'b1;
        start(42'h500, 42'h600, 16'd4);
        wait_rd(4, "bp_wait_rd");
        for (int t = 0; t < 4; t++) send_rsp(t, 8'(t + 1), 8'h10);
        repeat (50) @(negedge clk);
        chk("bp_no_write", 64'(wr_addr_q.size()), 0);
        wr_req_almfull = 1'b0;
        wait_wr(4, "bp_wait_wr");
        repeat (5) @(negedge clk);
        chk("bp_wr_count", 64'(wr_addr_q.size()), 4);
        for (int t = 0; t < 4 && t < wr_addr_q.size(); t++) begin
            chk("bp_wr_addr", wr_addr_q[t], 64'h600 + 64'(t));
            chk("bp_wr_data", wr_data_q[t], 64'h11 + 64'(t));
        end
        wr_rsp(4);
        repeat (3) @(negedge clk);
        chk("bp_done", 64'(done), 1);
        clear_q();

        // n = 0 from IDLE
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("n0_pre_done", 64'(done), 0);
        start(42'h50, 42'h60, 16'd0);
        chk("n0_done", 64'(done), 1);
        chk("n0_busy", 64'(busy), 0);
        repeat (10) @(negedge clk);
        chk("n0_no_rd", 64'(rd_addr_q.size()), 0);
        chk("n0_no_wr", 64'(wr_addr_q.size()), 0);

        // cfg_start while busy is ignored
        rd_req_almfull = 1'b1;
        start(42'h700, 42'h800, 16'd2);
        start(42'h900, 42'hA00, 16'd5);
        rd_req_almfull = 1'b0;
        wait_rd(2, "ign_wait_rd");
        repeat (10) @(negedge clk);
        chk("ign_rd_count", 64'(rd_addr_q.size()), 2);
        chk("ign_rd_addr1", rd_addr_q[1], 64'h701);
        send_rsp(0, 8'h01, 8'h01);
        send_rsp(1, 8'h02, 8'h02);
        wait_wr(2, "ign_wait_wr");
        chk("ign_wr_addr1", wr_addr_q[1], 64'h801);
        wr_rsp(2);
        repeat (3) @(negedge clk);
        chk("ign_lines", 64'(lines_done), 2);
        chk("ign_done", 64'(done), 1);
        clear_q();

        // reset in RUN aborts; late response ignored
        rd_req_almfull = 1'b1;
        start(42'hA00, 42'hB00, 16'd4);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("abort_rd_valid", 64'(rd_req_valid), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_lines", 64'(lines_done), 0);
        reset = 1'b0;
        rd_req_almfull = 1'b0;
        clear_q();
        send_rsp(0, 8'h33, 8'h44);
        repeat (10) @(negedge clk);
        chk("abort_no_wr", 64'(wr_addr_q.size()), 0);
        chk("abort_no_rd", 64'(rd_addr_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
